// File: rtl/mem_stream_writer.sv
// mem_stream_writer: packs a byte stream into little-endian 32-bit words and
// writes them to an Avalon-MM word memory starting at base_addr.
// Optional feature macro: MEM_STREAM_WRITER_CHECKSUM_EN adds a 16-bit running
// byte checksum output (cleared on an accepted start, held after done).
module mem_stream_writer #(
  parameter int MEM_DEPTH = 17740,
  parameter int ADDR_W    = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [16:0]       byte_count,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken
`ifdef MEM_STREAM_WRITER_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, FINISH} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [16:0]       rem;
  logic [1:0]        lane;
  logic [3:0][7:0]   lbuf;
  logic [3:0][7:0]   word_nx;
  logic [3:0]        be_nx;
  logic [31:0]       end_addr;
  logic              over;
  logic              accept;
  logic              load, wr_load, advance, done_nx, err_nx;

  // Exclusive end of the requested region, widened so no sum can wrap.
  assign end_addr = 32'(base_addr) + ((32'(byte_count) + 32'd3) >> 2);
  assign over     = end_addr > 32'(MEM_DEPTH);

  // Byte handshake; an aborting cycle never counts as progress.
  assign in_ready = (state == FILL);
  assign accept   = in_valid & in_ready & ~abort;

  assign busy           = (state != IDLE);
  assign mem_write      = (state == WRITE) & ~abort;
  assign mem_chipselect = mem_write;
  assign mem_clken      = reset_n;

  // Word being completed this cycle: buffered lanes plus the incoming byte.
  always_comb begin
    word_nx       = lbuf;
    word_nx[lane] = in_data;
    case (lane)
      2'd0:    be_nx = 4'b0001;
      2'd1:    be_nx = 4'b0011;
      2'd2:    be_nx = 4'b0111;
      default: be_nx = 4'b1111;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state and control strobes.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    wr_load  = 1'b0;
    advance  = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (byte_count == 17'd0) done_nx = 1'b1;
          else if (over)           err_nx  = 1'b1;
          else begin
            load     = 1'b1;
            state_nx = FILL;
          end
        end
      end
      FILL: begin
        if (abort) state_nx = IDLE;
        else if (accept && (lane == 2'd3 || rem == 17'd1)) begin
          wr_load  = 1'b1;
          state_nx = WRITE;
        end
      end
      WRITE: begin
        if (abort) state_nx = IDLE;
        else if (rem != 17'd0) begin
          advance  = 1'b1;
          state_nx = FILL;
        end else state_nx = FINISH;
      end
      FINISH: begin
        state_nx = IDLE;
        done_nx  = ~abort;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Transfer counters, lane buffer and status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr   <= '0;
      rem   <= '0;
      lane  <= '0;
      lbuf  <= '0;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      done  <= done_nx;
      error <= err_nx;
      if (load) begin
        ptr  <= base_addr;
        rem  <= byte_count;
        lane <= '0;
        lbuf <= '0;
      end else if (state != IDLE && state_nx == IDLE) begin
        // Leaving a transfer (finished or aborted): drop any partial word.
        rem  <= '0;
        lane <= '0;
        lbuf <= '0;
      end else begin
        if (accept) begin
          lbuf[lane] <= in_data;
          lane       <= lane + 2'd1;
          rem        <= rem - 17'd1;
        end
        // Pointer only moves when another word follows, so it stays in range.
        if (advance) begin
          ptr  <= ptr + ADDR_W'(1);
          lbuf <= '0;
        end
      end
    end
  end

  // Memory-side word registers: loaded on entry to WRITE, held otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_address    <= '0;
      mem_writedata  <= '0;
      mem_byteenable <= '0;
    end else if (wr_load) begin
      mem_address    <= ptr;
      mem_writedata  <= word_nx;
      mem_byteenable <= be_nx;
    end
  end

`ifdef MEM_STREAM_WRITER_CHECKSUM_EN
  // Running modulo-2^16 sum of accepted bytes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    checksum <= '0;
    else if (load)   checksum <= '0;
    else if (accept) checksum <= checksum + {8'h00, in_data};
  end
`endif

endmodule

// File: tb/tb_mem_stream_writer.sv
// Self-checking bench for mem_stream_writer: directed cases plus randomized
// transfers checked against a word-level reference model.
module tb_mem_stream_writer;
  localparam int DEPTH = 17740;
  typedef logic [7:0] byte_q_t[$];

  logic        clk = 0, reset_n = 0, start = 0, abort = 0, in_valid = 0;
  logic [14:0] base_addr = '0;
  logic [16:0] byte_count = '0;
  logic [7:0]  in_data = '0;
  logic        in_ready, busy, done, error, mem_chipselect, mem_write, mem_clken;
  logic [14:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
`ifdef MEM_STREAM_WRITER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int n_cmp = 0, n_bad = 0;
  logic [14:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic [3:0]  wq_be[$];
  int done_cnt = 0, err_cnt = 0;

  mem_stream_writer #(.MEM_DEPTH(DEPTH), .ADDR_W(15)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .base_addr(base_addr), .byte_count(byte_count), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .busy(busy), .done(done),
    .error(error), .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken)
`ifdef MEM_STREAM_WRITER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // Mid-cycle monitor of writes and status pulses.
  always @(negedge clk) begin
    if (mem_write || mem_chipselect) begin
      wq_addr.push_back(mem_address);
      wq_data.push_back(mem_writedata);
      wq_be.push_back((mem_write && mem_chipselect) ? mem_byteenable : 4'hx);
    end
    if (done)  done_cnt++;
    if (error) err_cnt++;
  end

  task automatic clear_mon();
    wq_addr.delete(); wq_data.delete(); wq_be.delete();
    done_cnt = 0; err_cnt = 0;
  endtask

  task automatic do_start(input logic [14:0] b, input logic [16:0] c);
    @(posedge clk); #1;
    start = 1; base_addr = b; byte_count = c;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  // Offer bytes with random valid gaps; stops after stop_after accepted.
  task automatic feed(input byte_q_t bytes, input int gap_pct, input int stop_after, output int sent);
    int idx = 0, cyc = 0;
    while (idx < bytes.size() && idx < stop_after && cyc < 4000) begin
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      in_data  = bytes[idx];
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 0;
    sent = idx;
  endtask

  // Full transfer, checked against the word-level model.
  task automatic do_transfer(input string name, input logic [14:0] b, input byte_q_t bytes,
                             input int gap_pct, input bit poke_start);
    int n = bytes.size(), nw, sent, cyc;
    logic [14:0] e_addr; logic [31:0] e_data; logic [3:0] e_be; logic [15:0] e_sum;
    clear_mon();
    do_start(b, 17'(n));
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL %s busy after start: got %b want 1", name, busy); end
    if (poke_start) do_start(15'h7000, 17'd4);
    feed(bytes, gap_pct, n, sent);
    cyc = 0;
    while (done_cnt == 0 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    idle_cycles(3);
    nw = (n + 3) / 4;
    n_cmp++;
    if (done_cnt != 1 || err_cnt != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s status: done_cnt=%0d err_cnt=%0d busy=%b want 1/0/0", name, done_cnt, err_cnt, busy);
    end
    n_cmp++;
    if (wq_addr.size() != nw) begin
      n_bad++; $display("FAIL %s write count: got %0d want %0d", name, wq_addr.size(), nw);
    end else begin
      for (int i = 0; i < nw; i++) begin
        e_addr = b + 15'(i); e_data = '0; e_be = '0;
        for (int j = 0; j < 4; j++)
          if (4*i + j < n) begin e_data[8*j +: 8] = bytes[4*i + j]; e_be[j] = 1'b1; end
        n_cmp++;
        if (wq_addr[i] !== e_addr || wq_data[i] !== e_data || wq_be[i] !== e_be) begin
          n_bad++;
          $display("FAIL %s word %0d: got a=%h d=%h be=%b want a=%h d=%h be=%b",
                   name, i, wq_addr[i], wq_data[i], wq_be[i], e_addr, e_data, e_be);
        end
      end
    end
    e_sum = '0;
    foreach (bytes[k]) e_sum = e_sum + 16'(bytes[k]);
`ifdef MEM_STREAM_WRITER_CHECKSUM_EN
    n_cmp++;
    if (checksum !== e_sum) begin
      n_bad++; $display("FAIL %s checksum: got %h want %h", name, checksum, e_sum);
    end
`endif
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({busy, done, error, in_ready, mem_chipselect, mem_write, mem_clken} !== 7'b0 ||
        mem_address !== '0 || mem_byteenable !== '0 || mem_writedata !== '0) begin
      n_bad++; $display("FAIL reset_state: outputs not all zero (busy=%b clken=%b addr=%h)", busy, mem_clken, mem_address);
    end
    @(negedge clk); #2; reset_n = 1;
    @(negedge clk);
    n_cmp++;
    if (mem_clken !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_release: clken=%b busy=%b in_ready=%b want 1/0/0", mem_clken, busy, in_ready);
    end
  endtask

  task automatic test_directed();
    byte_q_t q;
    q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    do_transfer("eight_bytes", 15'h10, q, 0, 0);
    q = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    do_transfer("six_bytes", 15'h0, q, 30, 0);
  endtask

  task automatic test_bounds();
    byte_q_t q;
    clear_mon();
    do_start(15'(DEPTH - 1), 17'd5);
    n_cmp++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL reject: error=%b busy=%b want 1/0", error, busy);
    end
    idle_cycles(4);
    n_cmp++;
    if (err_cnt != 1 || wq_addr.size() != 0 || done_cnt != 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL reject_after: err_cnt=%0d writes=%0d done_cnt=%0d want 1/0/0", err_cnt, wq_addr.size(), done_cnt);
    end
    q = {8'h11, 8'h22, 8'h33, 8'h44};
    do_transfer("top_word", 15'(DEPTH - 1), q, 20, 0);
  endtask

  task automatic test_zero_and_busy();
    byte_q_t q;
    clear_mon();
    do_start(15'h5, 17'd0);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL zero_count: done=%b busy=%b want 1/0", done, busy);
    end
    idle_cycles(4);
    n_cmp++;
    if (done_cnt != 1 || wq_addr.size() != 0) begin
      n_bad++; $display("FAIL zero_count_after: done_cnt=%0d writes=%0d want 1/0", done_cnt, wq_addr.size());
    end
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
    do_transfer("start_while_busy", 15'h100, q, 10, 1);
  endtask

  task automatic test_abort();
    byte_q_t q;
    int sent;
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
    clear_mon();
    do_start(15'h40, 17'd8);
    feed(q, 0, 3, sent);
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL abort_fill: busy=%b in_ready=%b want 0/0", busy, in_ready);
    end
    in_valid = 1;
    idle_cycles(10);
    in_valid = 0;
    n_cmp++;
    if (wq_addr.size() != 0 || done_cnt != 0) begin
      n_bad++; $display("FAIL abort_fill_after: writes=%0d done_cnt=%0d want 0/0", wq_addr.size(), done_cnt);
    end
    // Abort arriving in the write cycle itself.
    clear_mon();
    do_start(15'h50, 17'd4);
    feed(q, 0, 4, sent);
    abort = 1;
    @(negedge clk);
    n_cmp++;
    if (mem_write !== 1'b0 || mem_chipselect !== 1'b0) begin
      n_bad++; $display("FAIL abort_write: write=%b cs=%b want 0/0", mem_write, mem_chipselect);
    end
    @(posedge clk); #1;
    abort = 0;
    idle_cycles(5);
    n_cmp++;
    if (wq_addr.size() != 0 || done_cnt != 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL abort_write_after: writes=%0d done_cnt=%0d busy=%b want 0/0/0", wq_addr.size(), done_cnt, busy);
    end
  endtask

  task automatic test_reset_mid();
    byte_q_t q;
    int sent;
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
    clear_mon();
    do_start(15'h60, 17'd8);
    feed(q, 0, 5, sent);
    reset_n = 0;
    #1;
    n_cmp++;
    if ({busy, done, error, in_ready, mem_chipselect, mem_write, mem_clken} !== 7'b0 ||
        mem_address !== '0 || mem_byteenable !== '0 || mem_writedata !== '0) begin
      n_bad++; $display("FAIL reset_mid: outputs not zero (busy=%b addr=%h data=%h)", busy, mem_address, mem_writedata);
    end
    @(negedge clk); #2;
    reset_n = 1;
    clear_mon();
    in_valid = 1;
    idle_cycles(10);
    in_valid = 0;
    n_cmp++;
    if (wq_addr.size() != 0 || done_cnt != 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_after: writes=%0d done_cnt=%0d busy=%b want 0/0/0", wq_addr.size(), done_cnt, busy);
    end
  endtask

  task automatic test_random();
    byte_q_t q;
    int n, nw;
    logic [14:0] b;
    for (int t = 0; t < 12; t++) begin
      n = $urandom_range(1, 40);
      nw = (n + 3) / 4;
      b = (t % 4 == 3) ? 15'(DEPTH - nw) : 15'($urandom_range(0, DEPTH - nw));
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      do_transfer($sformatf("random_%0d", t), b, q, $urandom_range(0, 60), 0);
    end
  endtask

  task automatic test_checksum();
`ifdef MEM_STREAM_WRITER_CHECKSUM_EN
    byte_q_t q;
    q = {};
    for (int i = 0; i < 300; i++) q.push_back(8'hFF);
    do_transfer("checksum_300", 15'h0, q, 0, 0);
    n_cmp++;
    if (checksum !== 16'h2AD4) begin
      n_bad++; $display("FAIL checksum_const: got %h want 2ad4", checksum);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_bounds();
    test_zero_and_busy();
    test_abort();
    test_reset_mid();
    test_random();
    test_checksum();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
